// File: rtl/control_sequencer_pkg.sv
// control_sequencer_pkg: shared control-state encodings and opcode headers for the sequencer and decoder
package control_sequencer_pkg;
  typedef enum logic [3:0] {
    S_IF      = 4'd0,
    S_RF      = 4'd1,
    S_IMM2    = 4'd2,
    S_ALU_R3  = 4'd3,
    S_ALU_RI3 = 4'd4,
    S_ALU4    = 4'd5,
    S_BRANCH3 = 4'd6,
    S_MEM3    = 4'd7,
    S_LOAD4   = 4'd8,
    S_STORE4  = 4'd9,
    S_LOAD5   = 4'd10,
    S_JUMP3   = 4'd11,
    S_HALT    = 4'd12
  } cs_e;
  localparam logic [1:0] OP_ALU_R_HEADER      = 2'b00;
  localparam logic [1:0] OP_ALU_RI_HEADER     = 2'b01;
  localparam logic [2:0] OP_BRANCH_HEADER     = 3'b100;
  localparam logic [2:0] OP_MEMORY_REF_HEADER = 3'b101;
  localparam logic [5:0] OP_JUMP              = 6'b110000;
  localparam logic [5:0] OP_IMM_INJECT        = 6'b110001;
  localparam logic [5:0] OP_HALT              = 6'b111111;
  localparam int         OP_STORE_BIT         = 2;
  // Anything not matching a defined header falls through to HALT
  function automatic cs_e decode(input logic [5:0] op);
    return op[5:4] == OP_ALU_R_HEADER      ? S_ALU_R3  :
           op[5:4] == OP_ALU_RI_HEADER     ? S_ALU_RI3 :
           op[5:3] == OP_BRANCH_HEADER     ? S_BRANCH3 :
           op[5:3] == OP_MEMORY_REF_HEADER ? S_MEM3    :
           op      == OP_JUMP              ? S_JUMP3   :
           op      == OP_IMM_INJECT        ? S_IMM2    : S_HALT;
  endfunction
endpackage

// File: rtl/control_sequencer_retire_counter.sv
// retire_counter: wrapping retired-instruction counter with async clear and increment enable
module retire_counter #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   inc,
  output logic [COUNT_WIDTH-1:0] count
);
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (inc) count <= count + 1'b1;
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle instruction control FSM with halt/illegal detection and retire counting
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [5:0]             opcode,
  input  logic                   mem_ready,
  output logic [3:0]             state,
  output logic                   halted,
  output logic                   illegal_op,
  output logic [COUNT_WIDTH-1:0] instr_count
);
  cs_e  cur, nxt;
  logic retire, illegal_next;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cur        <= S_IF;
      illegal_op <= 1'b0;
    end else begin
      cur        <= nxt;
      illegal_op <= illegal_op | illegal_next;
    end
  always_comb begin
    nxt = S_IF;
    case (cur)
      S_IF:                nxt = mem_ready ? S_RF : S_IF;
      S_RF:                nxt = decode(opcode);
      S_ALU_R3, S_ALU_RI3: nxt = S_ALU4;
      S_MEM3:              nxt = opcode[OP_STORE_BIT] ? S_STORE4 : S_LOAD4;
      S_LOAD4:             nxt = mem_ready ? S_LOAD5 : S_LOAD4;
      S_STORE4:            nxt = mem_ready ? S_IF : S_STORE4;
      S_HALT:              nxt = S_HALT;
      default:             nxt = S_IF;
    endcase
  end
  // A legal halt retires on HALT entry; illegal opcodes never retire
  always_comb begin
    illegal_next = cur == S_RF && nxt == S_HALT && opcode != OP_HALT;
    retire       = (nxt == S_IF && cur inside {S_ALU4, S_BRANCH3, S_STORE4, S_LOAD5, S_JUMP3, S_IMM2}) ||
                   (cur == S_RF && opcode == OP_HALT);
  end
  assign state  = cur;
  assign halted = cur == S_HALT;
  retire_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (retire),
    .count(instr_count)
  );
endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have parameter COUNT_WIDTH, default 16, giving the width of the retired-instruction counter.
REQ-002 SHALL have clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have rst, input, 1, reset: asynchronous, active-high.
REQ-004 SHALL have opcode, input, 6, the instruction-register opcode field, valid from REGISTER_FETCH onward.
REQ-005 SHALL have mem_ready, input, 1, high when memory completes the current access.
REQ-006 SHALL have state, output, 4, the registered current state, driven directly to the control decoder.
REQ-007 SHALL have halted, output, 1, high while in HALT.
REQ-008 SHALL have illegal_op, output, 1, sticky flag set when HALT is entered on an undefined opcode.
REQ-009 SHALL have instr_count, output, COUNT_WIDTH, the number of retired instructions.

Function
REQ-010 SHALL encode states: INSTRUCTION_FETCH=0, REGISTER_FETCH=1, IMMEDIATE_INJECTION2=2, ALU_R3=3, ALU_RI3=4, ALU4=5, BRANCH3=6, MEMORY_REF3=7, LOAD4=8, STORE4=9, LOAD5=10, JUMP3=11, HALT=12; codes 13-15 are unreachable and SHALL transition to INSTRUCTION_FETCH.
REQ-011 SHALL hold INSTRUCTION_FETCH while mem_ready=0, then advance to REGISTER_FETCH.
REQ-012 SHALL decode opcode in REGISTER_FETCH only, with these next states:
- opcode[5:4]=00 -> ALU_R3
- opcode[5:4]=01 -> ALU_RI3
- opcode[5:3]=100 -> BRANCH3
- opcode[5:3]=101 -> MEMORY_REF3
- 110000 -> JUMP3
- 110001 -> IMMEDIATE_INJECTION2
- 111111 -> HALT without setting illegal_op
- any other opcode -> HALT with illegal_op set
REQ-013 SHALL sequence ALU_R3 and ALU_RI3 -> ALU4 -> INSTRUCTION_FETCH.
REQ-014 SHALL sequence MEMORY_REF3 -> STORE4 if opcode[2]=1, otherwise -> LOAD4.
REQ-015 SHALL hold LOAD4 and STORE4 while mem_ready=0, then advance LOAD4 -> LOAD5 -> INSTRUCTION_FETCH, and STORE4 -> INSTRUCTION_FETCH.
REQ-016 SHALL take BRANCH3, JUMP3 and IMMEDIATE_INJECTION2 -> INSTRUCTION_FETCH after one cycle.
REQ-017 SHALL leave HALT only through reset.
REQ-018 SHALL ignore mem_ready in all states other than INSTRUCTION_FETCH, LOAD4 and STORE4.
REQ-019 SHALL increment instr_count by 1 on each transition into INSTRUCTION_FETCH from ALU4, BRANCH3, STORE4, LOAD5, JUMP3 or IMMEDIATE_INJECTION2.
REQ-020 SHALL wrap instr_count modulo 2^COUNT_WIDTH, all-ones -> 0, with no saturation.
REQ-021 SHALL increment instr_count by 1 on a halting instruction (opcode 111111) at HALT entry; an illegal opcode SHALL NOT count.
REQ-022 SHALL have all outputs registered or decoded from registered state only, with no combinational path from opcode or mem_ready to any output.
REQ-023 SHALL execute every instruction with fixed latencies, excluding mem_ready stalls:
- ALU: 4 cycles
- load: 5 cycles
- store: 4 cycles
- branch, jump, immediate injection: 3 cycles

Reset
REQ-024 SHALL, on rst=1 at any time including mid-instruction or mid-stall, force state=INSTRUCTION_FETCH, halted=0, illegal_op=0 and instr_count=0 immediately, without waiting for clk.
REQ-025 SHALL begin fetch on the first rising clk after rst deasserts, with IF then held only by mem_ready.

Structure
REQ-026 SHALL take state encodings from the shared control-states package (CS), which this block and the control decoder both use.
REQ-027 SHALL take opcode headers (BRANCH_HEADER=100, MEMORY_REF_HEADER=101, JUMP, IMM_INJECT, HALT) from the shared opcodes package (OP), with no literal opcodes in the block body.
REQ-028 SHALL contain one sub-module, retire_counter, holding the COUNT_WIDTH counter with async clear and an increment enable; the next-state logic stays in control_sequencer.

Verification
REQ-029 Opcode 000010 with mem_ready held at 1 -> states 0,1,3,5,0 on consecutive cycles; instr_count 0->1.
REQ-030 Opcode 101000 (load) with mem_ready=0 for 3 cycles in LOAD4 -> state 8 held 4 cycles, then 10, then 0; instr_count +1.
REQ-031 Opcode 101100 (store) -> states 0,1,7,9,0; opcode 100010 -> 0,1,6,0; opcode 110000 -> 0,1,11,0; each retires 1.
REQ-032 Opcode 110111 -> state 12, halted=1, illegal_op=1, instr_count unchanged; further clocks keep state 12.
REQ-033 Preload instr_count to all-ones via 2^16-1 retirements (or force), then one ALU instruction -> instr_count wraps to 0.
REQ-034 Assert rst asynchronously mid-STORE4 stall -> state=0 and count=0 before the next clk edge; after release, fetch resumes normally.
